conv_controller: RTL and testbench
==================================

// Module: conv_controller
// PURPOSE
//  Sequencing FSM directly upstream of the convolution datapath; drives every datapath control/address input.
//  Per run: clears and loads the 4x4 filter, loads 4 image rows into the main buffer, and slides the window.
//  Per output pixel: 16-cycle MAC, one memory write-back. Each output row reloads the next 4 image rows.
//  start/busy/done handshake towards the top level or testbench.
// PARAMETERS
//  IMG_W        16   image width in pixels (bytes); multiple of 4
//  IMG_H        16   image height in rows
//  K            4    filter edge; fixed 4x4, 16 taps
//  FILTER_BASE  0    word address of the 4 filter words
//  IMG_BASE     4    word address of image row 0; WPR = IMG_W/4 words per row
//  OUT_BASE     512  byte-per-word address of output pixel 0; outputs are row-major
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-low reset
//  start          in   1   run request; sampled in IDLE only
//  busy           out  1   high from the cycle after start is accepted until DONE is left
//  done           out  1   one-cycle pulse in DONE
//  wEnBuff        out  1   main buffer write enable (LD_ROWS)
//  w_r_EnMem      out  1   1 = memory write of MAC result (WR); 0 = read; also clears accumulator
//  wEnFilter      out  1   filter buffer write enable (LD_FILT)
//  writeEnwindow  out  1   shift one column into window buffer (FILL)
//  readEnmac      out  1   filter/window read enable (MAC)
//  addEn          out  1   accumulator enable (MAC)
//  winRst         out  1   filter buffer clear (CLR)
//  filterCount    out  6   filter byte address: 4*word in LD_FILT; tap 0..15 in MAC
//  macCount       out  6   MAC tap number 1..16; 0 outside MAC (gates product to zero)
//  memAddress     out  10  memory word address
//  buffAddress    out  6   main buffer word address (LD_ROWS) / column index (FILL)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs and counters 0. Reset mid-run abandons the run; no done.
//  Memory read is combinational: readData is valid in the same cycle as memAddress.
//  States and transitions:
//   IDLE: outputs 0. start=1 -> CLR. start while not IDLE is ignored.
//   CLR: winRst=1 for 1 cycle -> LD_FILT.
//   LD_FILT: 4 cycles, i=0..3: wEnFilter=1, memAddress=FILTER_BASE+i, filterCount=4*i -> LD_ROWS.
//   LD_ROWS: 4*WPR cycles, k=0..4*WPR-1: wEnBuff=1, buffAddress=k, memAddress=IMG_BASE+r*WPR+k.
//    r = output row index. Exits to FILL with col=0.
//   FILL: writeEnwindow=1, buffAddress=col.
//    On col==0: 4 cycles, columns 0..3. Otherwise: 1 cycle, column col+3. Exits to MAC.
//   MAC: 16 cycles t=0..15: readEnmac=1, addEn=1, filterCount=t, macCount=t+1 -> WR.
//   WR: 1 cycle: w_r_EnMem=1, memAddress=OUT_BASE+r*(IMG_W-3)+col. Transitions:
//    col<IMG_W-4: col++ -> FILL.
//    elif r<IMG_H-4: r++, col=0 -> LD_ROWS.
//    else -> DONE.
//   DONE: done=1 for 1 cycle -> IDLE. busy low in IDLE only.
//  Width rules:
//   memAddress is computed in 10 bits and wraps modulo 1024. Parameters must keep the output region <1024
//    (compile-time assertion).
//   col and r counters are sized by $clog2 of their ranges; macCount never exceeds 16.
//  Only one enable group is active per cycle; LD_FILT and LD_ROWS never overlap.
//  Defaults: 13x13=169 outputs. Cycles per output row: 16+21+12*18=253.
//   start-accept edge = cycle 0. CLR in cycle 1; first done in cycle 1+1+4+13*253 = 3295.
// STRUCTURE
//  conv_pkg: state enum (IDLE,CLR,LD_FILT,LD_ROWS,FILL,MAC,WR,DONE); K, TAPS=16, MEM_AW=10, BUF_AW=6.
//  Sub-module conv_addr_gen: holds r/col/k/t counters and computes memAddress/buffAddress.
//   Counters advance on step strobes from the FSM.
//  Top-level FSM: state register plus registered (Moore) control outputs.
// TESTING
//  1. rst=0 mid-MAC with run at r=2, col=5 -> next edge-independent: all outputs 0, state IDLE.
//     After release no done, busy=0.
//  2. start pulse with defaults -> cycle 1 winRst=1. Cycles 2..5 wEnFilter=1, memAddress 0..3, filterCount 0,4,8,12.
//  3. Same run -> first WR memAddress=512; 169 WR cycles total; last at 680; done exactly in cycle 3295, one cycle wide.
//  4. Window fill -> first FILL of each row 4 writeEnwindow cycles, buffAddress 0..3. Later pixels 1 cycle, buffAddress col+3.
//  5. MAC window -> macCount 1..16 with filterCount 0..15, addEn=readEnmac=1 for 16 cycles.
//     macCount=0 in every non-MAC cycle.
//  6. start held high through whole run and re-pulsed during busy -> no restart. New run begins only from IDLE.
//     A second run is bit-identical in timing.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution sequencer: state encoding, filter geometry, address widths.
package conv_pkg;

    localparam int K      = 4;
    localparam int TAPS   = K * K;
    localparam int MEM_AW = 10;
    localparam int BUF_AW = 6;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LD_FILT,
        LD_ROWS,
        FILL,
        MAC,
        WR,
        DONE
    } convStateT;

    // Registered enable group, one bit per datapath strobe.
    typedef struct packed {
        logic busy;
        logic done;
        logic winRst;
        logic wEnFilter;
        logic wEnBuff;
        logic writeEnwindow;
        logic readEnmac;
        logic addEn;
        logic wrEnMem;
    } ctrlT;

    function automatic int cntWidth(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Purpose: row/column/step/tap counters and the memory/buffer/filter addresses they imply.
// Latency: addresses are combinational from registered state and counters, so they line up with the enables.
// Backpressure: none; counters only move on FSM step strobes.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W       = 16,
    parameter int IMG_H       = 16,
    parameter int FILTER_BASE = 0,
    parameter int IMG_BASE    = 4,
    parameter int OUT_BASE    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  convStateT         state,
    input  logic              runClr,
    input  logic              kStep,
    input  logic              tStep,
    input  logic              colStep,
    input  logic              rowStep,
    output logic              phaseLast,
    output logic              colLast,
    output logic              rowLast,
    output logic [5:0]        filterCount,
    output logic [5:0]        macCount,
    output logic [MEM_AW-1:0] memAddress,
    output logic [BUF_AW-1:0] buffAddress
);

    localparam int WPR       = IMG_W / K;
    localparam int ROW_WORDS = K * WPR;
    localparam int OUT_W     = IMG_W - K + 1;
    localparam int COL_W     = cntWidth(OUT_W);
    localparam int ROW_W     = cntWidth(IMG_H - K + 1);
    localparam int TW        = cntWidth(TAPS);

    logic [BUF_AW-1:0] k;
    logic [TW-1:0]     t;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  r;

    // k and t restart at zero whenever their phase is not being extended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k   <= '0;
            t   <= '0;
            col <= '0;
            r   <= '0;
        end else begin
            k <= kStep ? k + BUF_AW'(1) : '0;
            t <= tStep ? t + TW'(1) : '0;
            if (runClr) begin
                col <= '0;
                r   <= '0;
            end else if (colStep) begin
                col <= col + COL_W'(1);
            end else if (rowStep) begin
                col <= '0;
                r   <= r + ROW_W'(1);
            end
        end
    end

    always_comb begin
        phaseLast   = 1'b0;
        colLast     = (col == COL_W'(IMG_W - K));
        rowLast     = (r == ROW_W'(IMG_H - K));
        filterCount = '0;
        macCount    = '0;
        memAddress  = '0;
        buffAddress = '0;
        case (state)
            LD_FILT: begin
                phaseLast   = (k == BUF_AW'(K - 1));
                filterCount = k << 2;
                memAddress  = MEM_AW'(FILTER_BASE) + MEM_AW'(k);
            end
            LD_ROWS: begin
                phaseLast   = (k == BUF_AW'(ROW_WORDS - 1));
                buffAddress = k;
                memAddress  = MEM_AW'(IMG_BASE) + MEM_AW'(r) * MEM_AW'(WPR) + MEM_AW'(k);
            end
            FILL: begin
                // Column 0 primes the whole window; later pixels only shift in the new right column.
                phaseLast   = (col != '0) || (k == BUF_AW'(K - 1));
                buffAddress = (col == '0) ? k : BUF_AW'(col) + BUF_AW'(K - 1);
            end
            MAC: begin
                phaseLast   = (t == TW'(TAPS - 1));
                filterCount = 6'(t);
                macCount    = 6'(t) + 6'd1;
            end
            WR: begin
                memAddress = MEM_AW'(OUT_BASE) + MEM_AW'(r) * MEM_AW'(OUT_W) + MEM_AW'(col);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/conv_controller.sv
// Purpose: run sequencer for the 4x4 convolution datapath (filter load, row loads, window fill, MAC, write-back).
// Latency: enables are registered from the next state, so they coincide with the state they belong to.
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
module conv_controller
    import conv_pkg::*;
#(
    parameter int IMG_W       = 16,
    parameter int IMG_H       = 16,
    parameter int FILTER_BASE = 0,
    parameter int IMG_BASE    = 4,
    parameter int OUT_BASE    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wEnBuff,
    output logic              w_r_EnMem,
    output logic              wEnFilter,
    output logic              writeEnwindow,
    output logic              readEnmac,
    output logic              addEn,
    output logic              winRst,
    output logic [5:0]        filterCount,
    output logic [5:0]        macCount,
    output logic [MEM_AW-1:0] memAddress,
    output logic [BUF_AW-1:0] buffAddress
);

    if ((IMG_W % K) != 0 || IMG_W < K || IMG_H < K) begin : gBadGeometry
        $error("IMG_W must be a multiple of 4 and the image at least 4x4");
    end
    if (OUT_BASE + (IMG_H - K + 1) * (IMG_W - K + 1) > (1 << MEM_AW)) begin : gBadOutRegion
        $error("output region does not fit in the memory address space");
    end
    if (IMG_W > (1 << BUF_AW)) begin : gBadBuffer
        $error("four image rows do not fit in the main buffer");
    end

    convStateT state, nextState;
    ctrlT      ctrl, ctrlNext;
    logic      runClr, kStep, tStep, colStep, rowStep;
    logic      phaseLast, colLast, rowLast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctrl  <= '0;
        end else begin
            state <= nextState;
            ctrl  <= ctrlNext;
        end
    end

    always_comb begin
        nextState = state;
        runClr    = 1'b0;
        kStep     = 1'b0;
        tStep     = 1'b0;
        colStep   = 1'b0;
        rowStep   = 1'b0;
        case (state)
            IDLE:    if (start) begin nextState = CLR; runClr = 1'b1; end
            CLR:     nextState = LD_FILT;
            LD_FILT: if (phaseLast) nextState = LD_ROWS; else kStep = 1'b1;
            LD_ROWS: if (phaseLast) nextState = FILL;    else kStep = 1'b1;
            FILL:    if (phaseLast) nextState = MAC;     else kStep = 1'b1;
            MAC:     if (phaseLast) nextState = WR;      else tStep = 1'b1;
            WR: begin
                if (!colLast) begin
                    nextState = FILL;
                    colStep   = 1'b1;
                end else if (!rowLast) begin
                    nextState = LD_ROWS;
                    rowStep   = 1'b1;
                end else begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase

        ctrlNext      = '0;
        ctrlNext.busy = (nextState != IDLE);
        case (nextState)
            CLR:     ctrlNext.winRst        = 1'b1;
            LD_FILT: ctrlNext.wEnFilter     = 1'b1;
            LD_ROWS: ctrlNext.wEnBuff       = 1'b1;
            FILL:    ctrlNext.writeEnwindow = 1'b1;
            MAC: begin
                ctrlNext.readEnmac = 1'b1;
                ctrlNext.addEn     = 1'b1;
            end
            WR:      ctrlNext.wrEnMem       = 1'b1;
            DONE:    ctrlNext.done          = 1'b1;
            default: ;
        endcase
    end

    assign busy          = ctrl.busy;
    assign done          = ctrl.done;
    assign winRst        = ctrl.winRst;
    assign wEnFilter     = ctrl.wEnFilter;
    assign wEnBuff       = ctrl.wEnBuff;
    assign writeEnwindow = ctrl.writeEnwindow;
    assign readEnmac     = ctrl.readEnmac;
    assign addEn         = ctrl.addEn;
    assign w_r_EnMem     = ctrl.wrEnMem;

    conv_addr_gen #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .FILTER_BASE(FILTER_BASE),
        .IMG_BASE   (IMG_BASE),
        .OUT_BASE   (OUT_BASE)
    ) uAddrGen (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .runClr     (runClr),
        .kStep      (kStep),
        .tStep      (tStep),
        .colStep    (colStep),
        .rowStep    (rowStep),
        .phaseLast  (phaseLast),
        .colLast    (colLast),
        .rowLast    (rowLast),
        .filterCount(filterCount),
        .macCount   (macCount),
        .memAddress (memAddress),
        .buffAddress(buffAddress)
    );

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: every cycle of a run is compared against a cycle-number-to-phase model.
module tb_conv_controller;

    localparam int IMG_W     = 16;
    localparam int IMG_H     = 16;
    localparam int IMG_BASE  = 4;
    localparam int OUT_BASE  = 512;
    localparam int WPR       = IMG_W / 4;
    localparam int OUT_W     = IMG_W - 3;
    localparam int OUT_H     = IMG_H - 3;
    localparam int LDR       = 4 * WPR;
    localparam int FIRST_PIX = 4 + 16 + 1;
    localparam int PIX       = 1 + 16 + 1;
    localparam int ROW_CYC   = LDR + FIRST_PIX + (OUT_W - 1) * PIX;
    localparam int DONE_CYC  = 6 + OUT_H * ROW_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, wEnBuff, w_r_EnMem, wEnFilter, writeEnwindow, readEnmac, addEn, winRst;
    logic [5:0] filterCount, macCount, buffAddress;
    logic [9:0] memAddress;
    logic [36:0] obsVec;

    int errors = 0;
    int checks = 0;
    int wrCnt, doneCnt, doneAt, firstWr, lastWr;

    always #5 clk = ~clk;

    conv_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .wEnBuff(wEnBuff), .w_r_EnMem(w_r_EnMem),
        .wEnFilter(wEnFilter), .writeEnwindow(writeEnwindow), .readEnmac(readEnmac),
        .addEn(addEn), .winRst(winRst), .filterCount(filterCount), .macCount(macCount),
        .memAddress(memAddress), .buffAddress(buffAddress)
    );

    assign obsVec = {busy, done, wEnBuff, w_r_EnMem, wEnFilter, writeEnwindow, readEnmac, addEn, winRst,
                     filterCount, macCount, memAddress, buffAddress};

    // Expected outputs for cycle c of a run (cycle 0 = the IDLE cycle whose edge accepts start).
    function automatic logic [36:0] model(input int c);
        logic b, d, wb, wm, wf, ww, rm, ae, wr;
        logic [5:0] fc, mc, ba;
        logic [9:0] ma;
        int row, off, col, q, fl;
        b = 0; d = 0; wb = 0; wm = 0; wf = 0; ww = 0; rm = 0; ae = 0; wr = 0;
        fc = '0; mc = '0; ba = '0; ma = '0;
        if (c >= 1 && c <= DONE_CYC) b = 1;
        if (c == 1) begin
            wr = 1;
        end else if (c >= 2 && c <= 5) begin
            wf = 1; ma = 10'(c - 2); fc = 6'(4 * (c - 2));
        end else if (c >= 6 && c < DONE_CYC) begin
            row = (c - 6) / ROW_CYC;
            off = (c - 6) % ROW_CYC;
            if (off < LDR) begin
                wb = 1; ba = 6'(off); ma = 10'(IMG_BASE + row * WPR + off);
            end else begin
                off = off - LDR;
                if (off < FIRST_PIX) begin
                    col = 0; q = off; fl = 4;
                end else begin
                    col = 1 + (off - FIRST_PIX) / PIX; q = (off - FIRST_PIX) % PIX; fl = 1;
                end
                if (q < fl) begin
                    ww = 1; ba = (col == 0) ? 6'(q) : 6'(col + 3);
                end else if (q < fl + 16) begin
                    rm = 1; ae = 1; fc = 6'(q - fl); mc = 6'(q - fl + 1);
                end else begin
                    wm = 1; ma = 10'(OUT_BASE + row * OUT_W + col);
                end
            end
        end else if (c == DONE_CYC) begin
            d = 1;
        end
        return {b, d, wb, wm, wf, ww, rm, ae, wr, fc, mc, ma, ba};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: start toggles randomly during the run; mode 1: start held high throughout.
    task automatic runOnce(input int mode, input string tag);
        int gap;
        gap = $urandom_range(4, 0);
        for (int i = 0; i < gap; i++) begin
            start = 1'b0;
            tick();
            chk({tag, "-idle"}, 0, obsVec, '0);
        end
        start = 1'b1;
        wrCnt = 0; doneCnt = 0; doneAt = -1; firstWr = -1; lastWr = -1;
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            tick();
            chk(tag, c, obsVec, model(c));
            if (w_r_EnMem) begin
                if (wrCnt == 0) firstWr = int'(memAddress);
                lastWr = int'(memAddress);
                wrCnt++;
            end
            if (done) begin
                doneCnt++;
                doneAt = c;
            end
            if (c == DONE_CYC + 1) start = 1'b0;
            else start = (mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
        end
        chkInt({tag, "-firstWr"}, firstWr, 512);
        chkInt({tag, "-lastWr"}, lastWr, 680);
        chkInt({tag, "-wrCount"}, wrCnt, 169);
        chkInt({tag, "-doneCycle"}, doneAt, 3295);
        chkInt({tag, "-doneCount"}, doneCnt, 1);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("reset", 0, obsVec, '0);
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(1, 0));
            tick();
            chk("reset-hold", i, obsVec, '0);
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        chk("post-reset-idle", 0, obsVec, '0);

        runOnce(0, "run1");
        runOnce(1, "run2");

        // Abort a run in the MAC of output row 2, column 5 (tap 6) with an asynchronous reset.
        start = 1'b1;
        for (int c = 1; c <= 6 + 2 * ROW_CYC + 115; c++) begin
            tick();
            start = 1'b0;
            chk("run3", c, obsVec, model(c));
        end
        chkInt("run3-midMacTap", int'(macCount), 6);
        #2;
        rst = 1'b0;
        #1;
        chk("async-reset", 0, obsVec, '0);
        tick();
        chk("async-reset-edge", 0, obsVec, '0);
        rst = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) doneCnt++;
            chk("after-abort-idle", i, obsVec, '0);
        end
        chkInt("after-abort-noDone", doneCnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
